// File: rtl/forward_hazard_unit_pkg.sv
// Shared pipeline definitions for the EX-stage forwarding and load-use hazard logic.
package forward_hazard_unit_pkg;

    localparam int REG_W_DEF = 5;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_LDSTALL = 1'b1
    } state_t;

endpackage

// File: rtl/forward_hazard_unit_fwd_select.sv
// Mux31 select for one EX operand: the younger EX/MEM producer beats MEM/WB, $0 never forwards.
module fwd_select
    import forward_hazard_unit_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] i_src,
    input  logic [REG_W-1:0] i_exmem_dest,
    input  logic             i_exmem_regwrite,
    input  logic [REG_W-1:0] i_memwb_dest,
    input  logic             i_memwb_regwrite,
    output logic [1:0]       o_sel
);

    logic w_hit_mem;
    logic w_hit_wb;

    assign w_hit_mem = i_exmem_regwrite && (i_exmem_dest != '0) && (i_exmem_dest == i_src);
    assign w_hit_wb  = i_memwb_regwrite && (i_memwb_dest != '0) && (i_memwb_dest == i_src);

    always_comb begin
        o_sel = FWD_REGFILE;
        if (w_hit_mem)
            o_sel = FWD_MEM;
        else if (w_hit_wb)
            o_sel = FWD_WB;
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding-select and load-use stall control for the 5-stage core, driven from a
// private shadow of the ID/EX, EX/MEM and MEM/WB destination information.
module forward_hazard_unit
    import forward_hazard_unit_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [REG_W-1:0] IdRs,
    input  logic [REG_W-1:0] IdRt,
    input  logic             IdUsesRt,
    input  logic [REG_W-1:0] IdDest,
    input  logic             IdRegWrite,
    input  logic             IdMemRead,
    input  logic             Hold,
    input  logic             ExFlush,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             Stall,
    output logic             Bubble
);

    logic [REG_W-1:0] r_idex_rs;
    logic [REG_W-1:0] r_idex_rt;
    logic [REG_W-1:0] r_idex_dest;
    logic             r_idex_regwrite;
    logic             r_idex_memread;
    logic [REG_W-1:0] r_exmem_dest;
    logic             r_exmem_regwrite;
    logic [REG_W-1:0] r_memwb_dest;
    logic             r_memwb_regwrite;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_hazard;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_idex_rs        <= '0;
            r_idex_rt        <= '0;
            r_idex_dest      <= '0;
            r_idex_regwrite  <= 1'b0;
            r_idex_memread   <= 1'b0;
            r_exmem_dest     <= '0;
            r_exmem_regwrite <= 1'b0;
            r_memwb_dest     <= '0;
            r_memwb_regwrite <= 1'b0;
        end else if (!Hold) begin
            if (Bubble) begin
                r_idex_rs       <= '0;
                r_idex_rt       <= '0;
                r_idex_dest     <= '0;
                r_idex_regwrite <= 1'b0;
                r_idex_memread  <= 1'b0;
            end else begin
                r_idex_rs       <= IdRs;
                r_idex_rt       <= IdRt;
                r_idex_dest     <= IdDest;
                r_idex_regwrite <= IdRegWrite;
                r_idex_memread  <= IdMemRead;
            end
            r_exmem_dest     <= r_idex_dest;
            r_exmem_regwrite <= r_idex_regwrite;
            r_memwb_dest     <= r_exmem_dest;
            r_memwb_regwrite <= r_exmem_regwrite;
        end
    end

    fwd_select #(.REG_W(REG_W)) u_fwd_a (
        .i_src            (r_idex_rs),
        .i_exmem_dest     (r_exmem_dest),
        .i_exmem_regwrite (r_exmem_regwrite),
        .i_memwb_dest     (r_memwb_dest),
        .i_memwb_regwrite (r_memwb_regwrite),
        .o_sel            (ForwardA)
    );

    fwd_select #(.REG_W(REG_W)) u_fwd_b (
        .i_src            (r_idex_rt),
        .i_exmem_dest     (r_exmem_dest),
        .i_exmem_regwrite (r_exmem_regwrite),
        .i_memwb_dest     (r_memwb_dest),
        .i_memwb_regwrite (r_memwb_regwrite),
        .o_sel            (ForwardB)
    );

    // Only a load still in ID/EX is too late to forward from; everything else is covered above.
    assign w_hazard = r_idex_memread && r_idex_regwrite && (r_idex_dest != '0) &&
                      ((r_idex_dest == IdRs) || (IdUsesRt && (r_idex_dest == IdRt)));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            r_state <= ST_RUN;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        Stall       = 1'b0;
        Bubble      = 1'b0;
        if (Hold) begin
            w_state_nxt = r_state;
        end else if (ExFlush) begin
            Bubble      = 1'b1;
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_hazard) begin
                        Stall       = 1'b1;
                        Bubble      = 1'b1;
                        w_state_nxt = ST_LDSTALL;
                    end
                end
                ST_LDSTALL: w_state_nxt = ST_RUN;
                default:    w_state_nxt = ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed checks of forwarding selects, load-use stall, hold/flush priority and reset.
module tb_forward_hazard_unit;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [4:0] IdRs, IdRt, IdDest;
    logic       IdUsesRt, IdRegWrite, IdMemRead, Hold, ExFlush;
    logic [1:0] ForwardA, ForwardB;
    logic       Stall, Bubble;

    int total = 0;
    int bad   = 0;

    forward_hazard_unit #(.REG_W(5)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .IdRs       (IdRs),
        .IdRt       (IdRt),
        .IdUsesRt   (IdUsesRt),
        .IdDest     (IdDest),
        .IdRegWrite (IdRegWrite),
        .IdMemRead  (IdMemRead),
        .Hold       (Hold),
        .ExFlush    (ExFlush),
        .ForwardA   (ForwardA),
        .ForwardB   (ForwardB),
        .Stall      (Stall),
        .Bubble     (Bubble)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                          input logic [4:0] dest, input logic rw, input logic mr);
        IdRs = rs; IdRt = rt; IdUsesRt = uses_rt;
        IdDest = dest; IdRegWrite = rw; IdMemRead = mr;
        #1;
    endtask

    task automatic drain();
        set_id(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (4) step();
    endtask

    task automatic test_reset();
        Hold = 0; ExFlush = 0;
        set_id(5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1);
        Rst_n = 0;
        #1;
        total++;
        if ({ForwardA, ForwardB, Stall, Bubble} !== 6'b0) begin
            bad++; $display("FAIL reset_outputs got=%b exp=000000", {ForwardA, ForwardB, Stall, Bubble});
        end
        repeat (2) step();
        Rst_n = 1;
        drain();
    endtask

    task automatic test_back_to_back();
        set_id(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3,$1,$2
        step();
        set_id(5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);   // sub $4,$3,$5
        total++;
        if (Stall !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%b exp=0", Stall); end
        step();
        set_id(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        total++;
        if (ForwardA !== 2'b10) begin bad++; $display("FAIL b2b_fwdA got=%b exp=10", ForwardA); end
        total++;
        if (ForwardB !== 2'b00) begin bad++; $display("FAIL b2b_fwdB got=%b exp=00", ForwardB); end
        total++;
        if (Stall !== 1'b0) begin bad++; $display("FAIL b2b_stall_ex got=%b exp=0", Stall); end
        drain();
    endtask

    task automatic test_distance2();
        set_id(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3
        step();
        set_id(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);   // nop
        step();
        set_id(5'd5, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0);   // or $6,$5,$3
        step();
        set_id(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        total++;
        if (ForwardB !== 2'b01) begin bad++; $display("FAIL dist2_fwdB got=%b exp=01", ForwardB); end
        total++;
        if (ForwardA !== 2'b00) begin bad++; $display("FAIL dist2_fwdA got=%b exp=00", ForwardA); end
        drain();
        // both EX/MEM and MEM/WB hold $3: youngest wins
        set_id(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        step();
        set_id(5'd1, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);
        step();
        set_id(5'd5, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0);
        step();
        set_id(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        total++;
        if (ForwardB !== 2'b10) begin bad++; $display("FAIL both_fwdB got=%b exp=10", ForwardB); end
        drain();
    endtask

    task automatic test_load_use();
        set_id(5'd1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);   // lw $8,0($1)
        step();
        set_id(5'd8, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);   // add $9,$8,$2
        total++;
        if ({Stall, Bubble} !== 2'b11) begin bad++; $display("FAIL lu_stall got=%b exp=11", {Stall, Bubble}); end
        step();                                       // IF/ID held: add still in ID
        total++;
        if ({Stall, Bubble} !== 2'b00) begin bad++; $display("FAIL lu_release got=%b exp=00", {Stall, Bubble}); end
        step();
        set_id(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        total++;
        if (ForwardA !== 2'b01) begin bad++; $display("FAIL lu_fwdA got=%b exp=01", ForwardA); end
        total++;
        if (ForwardB !== 2'b00) begin bad++; $display("FAIL lu_fwdB got=%b exp=00", ForwardB); end
        drain();
        // Rt matches but is not a source
        set_id(5'd1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
        step();
        set_id(5'd1, 5'd8, 1'b0, 5'd9, 1'b1, 1'b0);
        total++;
        if (Stall !== 1'b0) begin bad++; $display("FAIL lu_nort_stall got=%b exp=0", Stall); end
        set_id(5'd1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
        total++;
        if (Stall !== 1'b1) begin bad++; $display("FAIL lu_rt_stall got=%b exp=1", Stall); end
        set_id(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_reg0();
        set_id(5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);   // add $0,$1,$2
        step();
        set_id(5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
        step();
        set_id(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        total++;
        if (ForwardA !== 2'b00) begin bad++; $display("FAIL r0_fwdA got=%b exp=00", ForwardA); end
        drain();
        set_id(5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);   // lw $0
        step();
        set_id(5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
        total++;
        if (Stall !== 1'b0) begin bad++; $display("FAIL r0_lw_stall got=%b exp=0", Stall); end
        drain();
    endtask

    task automatic test_hold_flush();
        set_id(5'd1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
        step();
        set_id(5'd8, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
        Hold = 1; #1;
        total++;
        if ({Stall, Bubble} !== 2'b00) begin bad++; $display("FAIL hold_outputs got=%b exp=00", {Stall, Bubble}); end
        step();
        total++;
        if ({Stall, Bubble} !== 2'b00) begin bad++; $display("FAIL hold_held got=%b exp=00", {Stall, Bubble}); end
        Hold = 0; #1;
        total++;
        if ({Stall, Bubble} !== 2'b11) begin bad++; $display("FAIL hold_release got=%b exp=11", {Stall, Bubble}); end
        step();
        total++;
        if (Stall !== 1'b0) begin bad++; $display("FAIL hold_ldstall got=%b exp=0", Stall); end
        step();
        set_id(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        total++;
        if (ForwardA !== 2'b01) begin bad++; $display("FAIL hold_fwdA got=%b exp=01", ForwardA); end
        drain();
        // flush during a hazard
        set_id(5'd1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
        step();
        set_id(5'd8, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
        ExFlush = 1; Hold = 1; #1;
        total++;
        if ({Stall, Bubble} !== 2'b00) begin bad++; $display("FAIL flushhold_outputs got=%b exp=00", {Stall, Bubble}); end
        Hold = 0; #1;
        total++;
        if ({Stall, Bubble} !== 2'b01) begin bad++; $display("FAIL flush_outputs got=%b exp=01", {Stall, Bubble}); end
        step();
        ExFlush = 0;
        set_id(5'd8, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
        total++;
        if ({Stall, Bubble} !== 2'b00) begin bad++; $display("FAIL flush_after got=%b exp=00", {Stall, Bubble}); end
        drain();
    endtask

    task automatic test_reset_mid_stall();
        set_id(5'd1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
        step();
        set_id(5'd8, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
        total++;
        if (Stall !== 1'b1) begin bad++; $display("FAIL rst_pre_stall got=%b exp=1", Stall); end
        step();                                       // now in LDSTALL, load in EX/MEM
        set_id(5'd8, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
        Rst_n = 0; #1;
        total++;
        if ({ForwardA, ForwardB, Stall, Bubble} !== 6'b0) begin
            bad++; $display("FAIL rst_mid_outputs got=%b exp=000000", {ForwardA, ForwardB, Stall, Bubble});
        end
        step();
        Rst_n = 1;
        total++;
        if (Stall !== 1'b0) begin bad++; $display("FAIL rst_after_stall got=%b exp=0", Stall); end
        step();
        set_id(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        total++;
        if ({ForwardA, ForwardB} !== 4'b0000) begin
            bad++; $display("FAIL rst_after_fwd got=%b exp=0000", {ForwardA, ForwardB});
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_distance2();
        test_load_use();
        test_reg0();
        test_hold_flush();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/forward_hazard_unit.md
# forward_hazard_unit

Pipeline control block that produces the 2-bit select codes for the EX-stage operand forwarding muxes (Mux31 instances) and the load-use stall for the 5-stage MIPS core. It keeps its own shadow copy of the destination-register information for the EX, MEM and WB stages, updated every clock. It is the producer side of the Mux31 Select interface. Select encoding: 00 = ID/EX register-file value, 01 = MEM/WB write-back value, 10 = EX/MEM ALU result.

## Interface
- REG_W, 5, register-specifier width
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous, active-low reset
- IdRs, IdRt  input  REG_W  source specifiers of the instruction in ID
- IdUsesRt  input  1  instruction in ID reads Rt as a source
- IdDest  input  REG_W  destination chosen in ID (after RegDst)
- IdRegWrite, IdMemRead  input  1  decoded control of the ID instruction
- Hold  input  1  global pipeline freeze (memory wait); all internal state held
- ExFlush  input  1  branch/jump resolved taken in EX; squash ID and IF instructions
- ForwardA, ForwardB  output  2  Mux31 Select for the EX-stage Rs and Rt operands
- Stall  output  1  hold PC and IF/ID this cycle
- Bubble  output  1  load zeros into ID/EX control this cycle

## Operation
- Shadow registers: ID/EX {Rs, Rt, Dest, RegWrite, MemRead}, EX/MEM {Dest, RegWrite}, MEM/WB {Dest, RegWrite}.
- Per Clk edge with Hold=0:
  - ID/EX loads the Id* inputs, or zeros when Bubble=1.
  - EX/MEM loads from ID/EX.
  - MEM/WB loads from EX/MEM.
- Hold=1: no shadow register changes. Outputs keep being computed from the held state.
- Forwarding, evaluated independently for A (ID/EX Rs) and B (ID/EX Rt):
  - 10 if EX/MEM RegWrite and Dest≠0 and Dest==src.
  - Otherwise 01 if MEM/WB RegWrite and Dest≠0 and Dest==src.
  - Otherwise 00.
  - When both stages match, EX/MEM wins.
  - Register 0 never forwards.
- Load-use hazard. It exists when all of these hold:
  - ID/EX MemRead=1 and ID/EX RegWrite=1 and ID/EX Dest≠0.
  - ID/EX Dest==IdRs, or (IdUsesRt and ID/EX Dest==IdRt).
- State machine RUN / LDSTALL:
  - RUN with hazard and Hold=0: Stall=1, Bubble=1, next state LDSTALL.
  - LDSTALL: the load has moved to EX/MEM and the bubble occupies ID/EX. Stall=0, Bubble=0, unconditional return to RUN.
  - If the ID instruction depends on a new back-to-back load, LDSTALL cannot occur: the bubble has no MemRead.
- ExFlush=1: Bubble=1 and Stall=0 regardless of hazard. The ID instruction is squashed, so no stall is needed. Next state RUN.
- Hold=1: Stall and Bubble are forced to 0 (the external freeze already holds everything). The FSM state is held.

## Timing
- ForwardA/B, Stall and Bubble are combinational from the registered shadow state plus the Id* inputs. They are valid in the same cycle; there are no registered outputs.
- Load-use costs exactly one stall cycle.
- The dependent instruction then forwards with select 01 from the load's MEM/WB.
- Reset (asynchronous, immediate):
  - All shadow RegWrite/MemRead = 0 and specifiers = 0; state = RUN.
  - Outputs ForwardA=ForwardB=00, Stall=0, Bubble=0.
- Reset asserted mid-stall drops Stall within the same cycle.
- ExFlush together with Hold: Hold takes priority (no update, outputs 0); the flush is expected to be reissued by EX.

## Structure
- Shared pipeline package holds:
  - FWD_REGFILE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - The REG_W default.
  - The RUN/LDSTALL state encoding.
- One natural sub-module: fwd_select (combinational compare, one instance each for A and B). Everything else stays in the top module.

## Test plan
- Back-to-back ALU dependency:
  - Stimulus: add $3,$1,$2 then sub $4,$3,$5.
  - Response: the cycle sub is in EX, ForwardA=10, ForwardB=00, Stall=0.
- Distance-2 dependency:
  - Stimulus: add $3, nop, or $6,$5,$3.
  - Response: ForwardB=01 when or is in EX.
  - Variant with both stages matching $3: ForwardB=10.
- Load-use:
  - Stimulus: lw $8,0($1) then add $9,$8,$2.
  - Response: Stall=1 and Bubble=1 for exactly 1 cycle, then ForwardA=01 for add in EX.
  - Variant with IdUsesRt=0 and Rt=$8: no stall.
- Register 0:
  - Stimulus: add $0,$1,$2 followed by a reader of $0.
  - Response: ForwardA=00.
  - lw $0 followed by a reader of $0: Stall=0.
- Hold/flush:
  - Hold=1 during a load-use: Stall=0, state frozen, and the stall fires once Hold drops.
  - ExFlush during a hazard: Bubble=1, Stall=0.
- Reset:
  - Stimulus: Rst_n low mid-LDSTALL.
  - Response: all outputs 0 immediately, and a dependent instruction after release forwards 00.
